// File: rtl/gray_counter_updown.sv
// rtl/gray_counter_updown.sv - parametrised up/down Gray counter with load, wrap/saturate and wrap pulse
module gray_counter_updown #(
  parameter int                WIDTH     = 4,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0,
  parameter bit                WRAP_EN   = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin,
  output logic             terminal,
  output logic             wrap_pulse
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] gray_q, gray_d;
  logic [WIDTH-1:0] bin_c;
  logic [WIDTH-1:0] bin_next;
  logic [WIDTH-1:0] set_c, rst_c;
  logic             wrap_q, wrap_d;
  logic             term_c;

  // Gray-to-binary: running XOR from the MSB down.
  always_comb begin
    logic acc;
    acc   = 1'b0;
    bin_c = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      acc      = acc ^ gray_q[i];
      bin_c[i] = acc;
    end
  end

  // Last value in the current direction: all ones going up, all zeros going down.
  always_comb begin
    term_c = up ? (&bin_c) : ~(|bin_c);
  end

  // Next-state selection: load beats count; terminal either wraps or holds.
  always_comb begin
    gray_d   = gray_q;
    wrap_d   = 1'b0;
    bin_next = bin_c;
    if (load) begin
      gray_d = load_val;
    end else if (en) begin
      if (!term_c) begin
        bin_next = up ? (bin_c + ONE) : (bin_c - ONE);
        gray_d   = bin_next ^ (bin_next >> 1);
      end else if (WRAP_EN) begin
        bin_next = up ? '0 : '1;
        gray_d   = bin_next ^ (bin_next >> 1);
        wrap_d   = 1'b1;
      end
    end
  end

  // Per-bit set/reset drive; a bit is never both set and cleared.
  always_comb begin
    set_c = ~gray_q & gray_d;
    rst_c = gray_q & ~gray_d;
  end

  // Set/reset state cells plus registered wrap pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gray_q <= RESET_VAL;
      wrap_q <= 1'b0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (set_c[i]) begin
          gray_q[i] <= 1'b1;
        end else if (rst_c[i]) begin
          gray_q[i] <= 1'b0;
        end
      end
      wrap_q <= wrap_d;
    end
  end

  assign gray       = gray_q;
  assign bin        = bin_c;
  assign terminal   = term_c;
  assign wrap_pulse = wrap_q;

endmodule

// File: tb/tb_gray_counter_updown.sv
// tb/tb_gray_counter_updown.sv - self-checking bench for gray_counter_updown (wrap/sat 4-bit, wrap 8-bit)
module tb_gray_counter_updown;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en, up, load;
  logic [3:0] load_val4;
  logic [7:0] load_val8;

  logic [3:0] g0, b0, g1, b1;
  logic [7:0] g2, b2;
  logic       t0, t1, t2, w0, w1, w2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  gray_counter_updown #(.WIDTH(4), .RESET_VAL(4'b0000), .WRAP_EN(1'b1)) u_w4 (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .load_val(load_val4),
    .gray(g0), .bin(b0), .terminal(t0), .wrap_pulse(w0));

  gray_counter_updown #(.WIDTH(4), .RESET_VAL(4'b0000), .WRAP_EN(1'b0)) u_sat (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .load_val(load_val4),
    .gray(g1), .bin(b1), .terminal(t1), .wrap_pulse(w1));

  gray_counter_updown #(.WIDTH(8), .RESET_VAL(8'h00), .WRAP_EN(1'b1)) u_w8 (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .load_val(load_val8),
    .gray(g2), .bin(b2), .terminal(t2), .wrap_pulse(w2));

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Behavioural model: binary value per instance, modular arithmetic.
  int mx[3]  = '{15, 15, 255};
  int wen[3] = '{1, 0, 1};
  int mb[3];
  int mwp[3];
  int msk[3];

  function automatic int g2b(input int g);
    int r;
    r = g;
    for (int s = 1; s < 16; s++) r = r ^ (g >> s);
    return r;
  endfunction

  function automatic int at_term(input int b, input int m, input logic u);
    return u ? int'(b == m) : int'(b == 0);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        mb[i] <= 0; mwp[i] <= 0; msk[i] <= 0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (load) begin
          mb[i]  <= g2b((i == 2) ? int'(load_val8) : int'(load_val4));
          mwp[i] <= 0; msk[i] <= 0;
        end else if (en) begin
          if (at_term(mb[i], mx[i], up) != 0) begin
            if (wen[i] != 0) begin
              mb[i] <= up ? 0 : mx[i]; mwp[i] <= 1; msk[i] <= 1;
            end else begin
              mwp[i] <= 0; msk[i] <= 0;
            end
          end else begin
            mb[i]  <= up ? ((mb[i] + 1) & mx[i]) : ((mb[i] - 1) & mx[i]);
            mwp[i] <= 0; msk[i] <= 1;
          end
        end else begin
          mwp[i] <= 0; msk[i] <= 0;
        end
      end
    end
  end

  // Every-cycle comparison against the model, plus one-bit-change check on count steps.
  int pg[3];
  int pvalid = 0;
  always @(negedge clk) begin
    int dg[3], db[3], dt[3], dw[3];
    dg[0] = int'(g0); db[0] = int'(b0); dt[0] = int'(t0); dw[0] = int'(w0);
    dg[1] = int'(g1); db[1] = int'(b1); dt[1] = int'(t1); dw[1] = int'(w1);
    dg[2] = int'(g2); db[2] = int'(b2); dt[2] = int'(t2); dw[2] = int'(w2);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("model_gray[%0d]", i), dg[i], mb[i] ^ (mb[i] >> 1));
      chk($sformatf("model_bin[%0d]", i), db[i], mb[i]);
      chk($sformatf("model_terminal[%0d]", i), dt[i], at_term(mb[i], mx[i], up));
      chk($sformatf("model_wrap[%0d]", i), dw[i], mwp[i]);
      if (pvalid != 0 && msk[i] != 0)
        chk($sformatf("hamming[%0d]", i), $countones(dg[i] ^ pg[i]), 1);
      pg[i] = dg[i];
    end
    pvalid = 1;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  logic [3:0] seq[17] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                          4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000,
                          4'b0000};

  initial begin
    int wraps;
    rst_n = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; load_val4 = '0; load_val8 = '0;
    #12;
    chk("reset_gray", int'(g0), 0);
    chk("reset_wrap", int'(w0), 0);
    rst_n = 1'b1;

    // T2: up sweep on the 4-bit wrapping counter
    en = 1'b1; up = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("t2_term_before[%0d]", i), int'(t0), int'(seq[i] == 4'b1000));
      tick();
      chk($sformatf("t2_gray[%0d]", i), int'(g0), int'(seq[i+1]));
      chk($sformatf("t2_wrap[%0d]", i), int'(w0), int'(i == 15));
    end

    // T3: down wrap from zero
    up = 1'b0;
    tick();
    chk("t3_gray", int'(g0), 4'b1000);
    chk("t3_bin", int'(b0), 4'b1111);
    chk("t3_wrap", int'(w0), 1);
    tick();
    chk("t3_gray2", int'(g0), 4'b1001);
    chk("t3_bin2", int'(b0), 4'b1110);
    chk("t3_wrap2", int'(w0), 0);

    // T4: load wins over enable
    load = 1'b1; load_val4 = 4'b1010; up = 1'b1;
    tick();
    chk("t4_gray", int'(g0), 4'b1010);
    chk("t4_bin", int'(b0), 4'b1100);
    chk("t4_wrap", int'(w0), 0);
    load = 1'b0;
    tick();
    chk("t4_gray2", int'(g0), 4'b1011);
    chk("t4_bin2", int'(b0), 4'b1101);

    // T5: saturation on the non-wrapping counter
    load = 1'b1; load_val4 = 4'b1000;
    tick();
    load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("t5_gray[%0d]", i), int'(g1), 4'b1000);
      chk($sformatf("t5_term[%0d]", i), int'(t1), 1);
      chk($sformatf("t5_wrap[%0d]", i), int'(w1), 0);
    end
    up = 1'b0;
    #1;
    chk("t5_term_down", int'(t1), 0);
    tick();
    chk("t5_gray_down", int'(g1), 4'b1001);

    // T6: enable low holds (wrapping counter sits at 0001 here)
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("t6_hold[%0d]", i), int'(g0), 4'b0001);
    end

    // T1: asynchronous reset in mid-count
    load = 1'b1; load_val4 = 4'b0110;
    tick();
    load = 1'b0;
    chk("t1_pre", int'(g0), 4'b0110);
    en = 1'b1; up = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    chk("t1_gray", int'(g0), 0);
    chk("t1_bin", int'(b0), 0);
    chk("t1_wrap", int'(w0), 0);
    tick();
    tick();
    chk("t1_held", int'(g0), 0);
    #3;
    rst_n = 1'b1;
    tick();
    chk("t1_resume", int'(g0), 4'b0001);

    // 8-bit full sweep from reset
    rst_n = 1'b0;
    #4;
    rst_n = 1'b1;
    wraps = 0;
    for (int i = 0; i < 256; i++) begin
      tick();
      if (w2) wraps++;
    end
    chk("w8_final_gray", int'(g2), 0);
    chk("w8_wraps", wraps, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
